common_clkmon: RTL and testbench
================================

// Module: common_clkmon
// PURPOSE
//   Receive-side companion to the hard clock buffers: monitors a buffered clock (mon_clk) from the
//   reference clock domain (clk). Counts mon_clk rising edges over a fixed window of clk cycles and
//   reports count plus lost/slow/fast/ok status. Sits next to each clock buffer output needing supervision.
// PARAMETERS
//   WINDOW       1024  clk cycles per measurement window (>=4)
//   CNT_W        16    width of edge counter / thresholds / meas_cnt
//   SYNC_STAGES  2     synchroniser flops, mon_clk toggle -> clk domain (>=2)
// PORTS
//   clk        in   1      reference clock; all outputs in this domain
//   rst_n      in   1      asynchronous active-low reset, both domains
//   mon_clk    in   1      monitored clock, f_mon <= f_clk/2 guaranteed by use
//   en         in   1      1 = measure continuously, 0 = idle
//   lo_thr     in   CNT_W  min acceptable edges per window (sampled at window end)
//   hi_thr     in   CNT_W  max acceptable edges per window (sampled at window end)
//   clr        in   1      clear sticky flags (port present only with CLKMON_STICKY_EN)
//   meas_cnt   out  CNT_W  edge count of last completed window
//   meas_vld   out  1      1-cycle pulse: meas_cnt and flags updated
//   clk_lost   out  1      last window count == 0
//   clk_slow   out  1      last window count < lo_thr (includes lost)
//   clk_fast   out  1      last window count > hi_thr
//   clk_ok     out  1      >=1 window completed, not slow, not fast
// BEHAVIOUR
//   - Reset: all outputs 0, FSM IDLE, counters 0, mon_clk toggle flop 0 (reset asynchronously too).
//   - mon_clk domain: toggle flop inverts on every mon_clk rising edge; nothing else there.
//   - clk domain: toggle through SYNC_STAGES flops, then one more flop; XOR of last two = edge strobe,
//     exactly one clk-cycle strobe per mon_clk rising edge.
//   - FSM IDLE: counters held 0; en=1 -> ARM.
//   - ARM: SYNC_STAGES+1 cycles flushing synchroniser, strobes ignored; then MEASURE, win_cnt=0.
//   - MEASURE: win_cnt counts 0..WINDOW-1 ($clog2(WINDOW) bits); edge_cnt += strobe, saturating at
//     2^CNT_W-1. Terminal cycle (win_cnt==WINDOW-1): meas_cnt <= edge_cnt+strobe (saturated);
//     edge_cnt <= 0, win_cnt <= 0; flags recomputed from new count; meas_vld high next cycle only.
//     No strobe lost or double-counted across window boundaries; windows back-to-back.
//   - Latency: meas_vld asserts exactly 1 cycle after the terminal cycle.
//   - en=0 in ARM/MEASURE: abort to IDLE next cycle, partial window discarded, no meas_vld,
//     meas_cnt and flags hold last values. Re-enable restarts via ARM.
//   - Comparisons unsigned, full CNT_W; lo_thr > hi_thr is legal (both slow and fast may assert).
//   - rst_n asserted mid-window: immediate return to reset state, no pulse.
// CONFIGURATION
//   CLKMON_STICKY_EN defined: clk_lost/slow/fast are sticky (set on a bad window, held through good
//     windows); cleared only by clr=1 (cycle after), set wins if clr coincides with a bad window;
//     clk_ok = window seen & no sticky flag set. clr port exists.
//   Not defined: flags reflect last window only; no clr port.
// TESTING  (WINDOW=64, SYNC_STAGES=2, clk 100 MHz, lo_thr=12, hi_thr=20)
//   1. rst_n=0 with mon_clk running -> all outputs 0; release, en=0 for 200 cycles -> meas_vld never 1.
//   2. en=1, mon_clk 25 MHz -> first meas_vld 3+64+1 cycles after en; meas_cnt in 15..17, clk_ok=1,
//      subsequent pulses every 64 cycles.
//   3. stop mon_clk -> within 2 windows meas_cnt=0, clk_lost=1, clk_slow=1, clk_ok=0;
//      restart 25 MHz -> next full window clk_ok=1, flags 0 (macro off).
//   4. mon_clk 40 MHz -> meas_cnt 25..26, clk_fast=1, clk_ok=0; lo_thr=30 hi_thr=10 -> slow=fast=1.
//   5. en=0 at window cycle 30 -> no meas_vld, outputs hold; en=1 -> next pulse 68 cycles later;
//      rst_n pulse at window cycle 40 -> outputs 0 immediately.
//   6. CLKMON_STICKY_EN: 1 lost window then good windows -> clk_lost stays 1; clr=1 -> 0 next cycle;
//      clr coincident with bad terminal window -> flag remains 1.

Source files
------------

// File: rtl/common_clkmon.sv
// -----------------------------------------------------------------------------
// common_clkmon
//   Clock supervisor placed next to a hard clock buffer output. Counts rising
//   edges of the buffered clock (mon_clk) over a fixed window of reference
//   clock (clk) cycles and reports the count plus lost/slow/fast/ok status.
//
// Parameters
//   WINDOW       clk cycles per measurement window (>= 4)
//   CNT_W        width of edge counter, thresholds and meas_cnt
//   SYNC_STAGES  synchroniser flops for the mon_clk toggle (>= 2)
//
// Ports
//   clk        in   reference clock; every output lives in this domain
//   rst_n      in   asynchronous active-low reset for both domains
//   mon_clk    in   monitored clock (f_mon <= f_clk/2)
//   en         in   1 = measure back-to-back windows, 0 = idle
//   lo_thr     in   minimum acceptable edges per window (used at window end)
//   hi_thr     in   maximum acceptable edges per window (used at window end)
//   clr        in   clear sticky flags (only with CLKMON_STICKY_EN)
//   meas_cnt   out  edge count of the last completed window
//   meas_vld   out  one-cycle pulse: meas_cnt and flags were just updated
//   clk_lost   out  last window counted zero edges
//   clk_slow   out  last window below lo_thr (lost counts as slow)
//   clk_fast   out  last window above hi_thr
//   clk_ok     out  at least one window done and neither slow nor fast
//   dbg_state  out  current FSM state (0 IDLE, 1 ARM, 2 MEASURE)
//
// Configuration macro
//   CLKMON_STICKY_EN  lost/slow/fast become sticky until clr; adds clr port.
//
// Handshake: meas_vld is a bare strobe with no ready/backpressure; a consumer
// must capture meas_cnt and the flags in the cycle meas_vld is high, although
// both also hold until the next completed window.
// -----------------------------------------------------------------------------
module common_clkmon #(
  parameter int WINDOW      = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             en,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
`ifdef CLKMON_STICKY_EN
  input  logic             clr,
`endif
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_vld,
  output logic             clk_lost,
  output logic             clk_slow,
  output logic             clk_fast,
  output logic             clk_ok,
  output logic [1:0]       dbg_state
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_MEASURE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_term;
  logic                   w_measuring;

  logic                   r_mon_tgl;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   w_strobe;

  logic [ARM_W-1:0]       r_arm_cnt;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic [CNT_W-1:0]       w_edge_sum;

  logic [CNT_W-1:0]       r_meas_cnt;
  logic                   r_vld;
  logic                   r_lost;
  logic                   r_slow;
  logic                   r_fast;
  logic                   r_seen;
  logic                   w_new_lost;
  logic                   w_new_slow;
  logic                   w_new_fast;

  // Monitored domain: a single toggle flop, one inversion per rising edge.
  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) r_mon_tgl <= 1'b0;
    else        r_mon_tgl <= ~r_mon_tgl;
  end

  // Toggle synchroniser plus one extra flop; any change of the synchronised
  // toggle yields exactly one clk-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], r_mon_tgl};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_strobe = r_sync[SYNC_STAGES-1] ^ r_sync_d;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; dropping en aborts immediately, even on the terminal cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_term      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (!en)                        w_state_nxt = S_IDLE;
        else if (r_arm_cnt == ARM_LAST) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (!en) w_state_nxt = S_IDLE;
        else     w_term = (r_win_cnt == WIN_LAST);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_measuring = (r_state == S_MEASURE) && en;

  // Saturating edge sum including this cycle's strobe, so the strobe on the
  // terminal cycle lands in the closing window and is not carried over.
  assign w_edge_sum = (&r_edge_cnt) ? r_edge_cnt
                                    : r_edge_cnt + {{(CNT_W-1){1'b0}}, w_strobe};

  assign w_new_lost = (w_edge_sum == '0);
  assign w_new_slow = w_new_lost | (w_edge_sum < lo_thr);
  assign w_new_fast = (w_edge_sum > hi_thr);

  // Counters are forced to zero whenever they are not actively in use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt  <= '0;
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_arm_cnt  <= (r_state == S_ARM && en) ? r_arm_cnt + 1'b1 : '0;
      r_win_cnt  <= w_measuring ? (w_term ? '0 : r_win_cnt + 1'b1) : '0;
      r_edge_cnt <= (w_measuring && !w_term) ? w_edge_sum : '0;
    end
  end

  // Result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_cnt <= '0;
      r_vld      <= 1'b0;
      r_lost     <= 1'b0;
      r_slow     <= 1'b0;
      r_fast     <= 1'b0;
      r_seen     <= 1'b0;
    end else begin
      r_vld  <= w_term;
      r_seen <= r_seen | w_term;
      if (w_term) r_meas_cnt <= w_edge_sum;
`ifdef CLKMON_STICKY_EN
      // Set has priority over a coincident clear.
      r_lost <= (r_lost & ~clr) | (w_term & w_new_lost);
      r_slow <= (r_slow & ~clr) | (w_term & w_new_slow);
      r_fast <= (r_fast & ~clr) | (w_term & w_new_fast);
`else
      if (w_term) begin
        r_lost <= w_new_lost;
        r_slow <= w_new_slow;
        r_fast <= w_new_fast;
      end
`endif
    end
  end

  assign meas_cnt  = r_meas_cnt;
  assign meas_vld  = r_vld;
  assign clk_lost  = r_lost;
  assign clk_slow  = r_slow;
  assign clk_fast  = r_fast;
  assign clk_ok    = r_seen & ~r_lost & ~r_slow & ~r_fast;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_common_clkmon.sv
`timescale 1ns/100ps
module tb_common_clkmon;

  localparam int WINDOW      = 64;
  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int ARM_LEN     = SYNC_STAGES + 1;
  localparam int FIRST_LAT   = ARM_LEN + WINDOW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             rst_n;
  logic             mon_clk;
  logic             en;
  logic [CNT_W-1:0] lo_thr;
  logic [CNT_W-1:0] hi_thr;
`ifdef CLKMON_STICKY_EN
  logic             clr;
`endif
  logic [CNT_W-1:0] meas_cnt;
  logic             meas_vld;
  logic             clk_lost;
  logic             clk_slow;
  logic             clk_fast;
  logic             clk_ok;
  logic [1:0]       dbg_state;

  common_clkmon #(
    .WINDOW(WINDOW), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mon_clk(mon_clk), .en(en),
    .lo_thr(lo_thr), .hi_thr(hi_thr),
`ifdef CLKMON_STICKY_EN
    .clr(clr),
`endif
    .meas_cnt(meas_cnt), .meas_vld(meas_vld), .clk_lost(clk_lost),
    .clk_slow(clk_slow), .clk_fast(clk_fast), .clk_ok(clk_ok),
    .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitored clock: rising edges always land 2-3 ns away from clk edges.
  bit  mon_run  = 1'b1;
  real mon_half = 20.0;
  int  cyc      = 0;
  int  mon_log[$];  // clk edge index at which each mon_clk edge must be counted

  initial begin
    mon_clk = 1'b0;
    #3;
    forever begin
      if (mon_run) begin
        mon_clk = 1'b1;
        // Captured by the next clk edge, through the sync stages, then counted
        // on the edge after the strobe cycle.
        if (rst_n) mon_log.push_back(cyc + 1 + SYNC_STAGES);
        #(mon_half);
        mon_clk = 1'b0;
        #(mon_half);
      end else begin
        #10;
      end
    end
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_err    = 0;
  int dut_vld_n = 0;
  logic [CNT_W-1:0] exp_q[$];

  bit               active, seen;
  int               e0;
  logic             exp_vld, exp_lost, exp_slow, exp_fast, exp_ok;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  task automatic reset_model();
    active   = 1'b0;
    seen     = 1'b0;
    exp_vld  = 1'b0;
    exp_cnt  = '0;
    exp_lost = 1'b0;
    exp_slow = 1'b0;
    exp_fast = 1'b0;
    exp_ok   = 1'b0;
    mon_log.delete();
  endtask

  // Window k after enable closes on clk edge e0 + ARM_LEN + WINDOW*(k+1) and
  // holds the mon_clk edges counted on the WINDOW edges ending there.
  task automatic model_step();
    int n;
    bit l_n, s_n, f_n;
    cyc++;
    exp_vld = 1'b0;
    if (!rst_n) begin
      reset_model();
    end else begin
      while (mon_log.size() > 0 && mon_log[0] < cyc - 400) mon_log.delete(0);
`ifdef CLKMON_STICKY_EN
      if (clr) begin
        exp_lost = 1'b0;
        exp_slow = 1'b0;
        exp_fast = 1'b0;
      end
`endif
      if (!active) begin
        if (en) begin
          active = 1'b1;
          e0     = cyc;
        end
      end else if (!en) begin
        active = 1'b0;
      end else if (cyc - e0 >= ARM_LEN + WINDOW &&
                   ((cyc - e0 - ARM_LEN - WINDOW) % WINDOW) == 0) begin
        n = 0;
        foreach (mon_log[i]) if (mon_log[i] > cyc - WINDOW && mon_log[i] <= cyc) n++;
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        l_n = (n == 0);
        s_n = l_n || (n < int'(lo_thr));
        f_n = (n > int'(hi_thr));
        exp_vld = 1'b1;
        exp_cnt = CNT_W'(n);
        exp_q.push_back(CNT_W'(n));
        seen = 1'b1;
`ifdef CLKMON_STICKY_EN
        exp_lost = exp_lost | l_n;
        exp_slow = exp_slow | s_n;
        exp_fast = exp_fast | f_n;
`else
        exp_lost = l_n;
        exp_slow = s_n;
        exp_fast = f_n;
`endif
      end
      exp_ok = seen && !exp_lost && !exp_slow && !exp_fast;
    end
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge rst_n);
    reset_model();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("meas_vld", meas_vld, exp_vld);
    chk("meas_cnt", meas_cnt, exp_cnt);
    chk("clk_lost", clk_lost, exp_lost);
    chk("clk_slow", clk_slow, exp_slow);
    chk("clk_fast", clk_fast, exp_fast);
    chk("clk_ok",   clk_ok,   exp_ok);
    if (meas_vld) begin
      dut_vld_n++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_spurious: meas_vld with cnt %0d but no window expected", meas_cnt);
      end else begin
        chk("sb_cnt", meas_cnt, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_vld(input string name, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!meas_vld && lat < 200);
    if (!meas_vld) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: no meas_vld within %0d cycles", name, lat);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cnt"},  meas_cnt, 0);
    chk({name, "_vld"},  meas_vld, 0);
    chk({name, "_lost"}, clk_lost, 0);
    chk({name, "_slow"}, clk_slow, 0);
    chk({name, "_fast"}, clk_fast, 0);
    chk({name, "_ok"},   clk_ok,   0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int lat;
    int vld_before;
    rst_n  = 1'b0;
    en     = 1'b0;
    lo_thr = 16'd12;
    hi_thr = 16'd20;
`ifdef CLKMON_STICKY_EN
    clr    = 1'b0;
`endif

    // 1: reset with mon_clk running, then idle with en=0
    repeat (10) @(negedge clk);
    chk_all_zero("rst");
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_no_vld", dut_vld_n, 0);
    chk("idle_state", dbg_state, 0);

    // 2: 25 MHz, first pulse latency then back-to-back windows
    en = 1'b1;
    wait_vld("first_vld", lat);
    chk("first_lat", lat, FIRST_LAT);
    chk_rng("cnt_25m", meas_cnt, 15, 17);
    chk("ok_25m", clk_ok, 1);
    wait_vld("second_vld", lat);
    chk("period", lat, WINDOW);
    chk_rng("cnt_25m_b", meas_cnt, 15, 17);

    // 3: stop mon_clk, then restart
    mon_run = 1'b0;
    wait_vld("stop_a", lat);
    wait_vld("stop_b", lat);
    chk("lost_cnt", meas_cnt, 0);
    chk("lost_lost", clk_lost, 1);
    chk("lost_slow", clk_slow, 1);
    chk("lost_ok", clk_ok, 0);
    mon_run = 1'b1;
    wait_vld("restart_a", lat);
    wait_vld("restart_b", lat);
    chk_rng("restart_cnt", meas_cnt, 15, 17);
`ifndef CLKMON_STICKY_EN
    chk("restart_ok", clk_ok, 1);
    chk("restart_lost", clk_lost, 0);
    chk("restart_slow", clk_slow, 0);
    chk("restart_fast", clk_fast, 0);

    // 4: 40 MHz is fast; crossed thresholds give slow and fast together
    mon_half = 12.5;
    wait_vld("fast_a", lat);
    wait_vld("fast_b", lat);
    chk_rng("fast_cnt", meas_cnt, 25, 26);
    chk("fast_fast", clk_fast, 1);
    chk("fast_ok", clk_ok, 0);
    lo_thr = 16'd30;
    hi_thr = 16'd10;
    wait_vld("cross", lat);
    chk("cross_slow", clk_slow, 1);
    chk("cross_fast", clk_fast, 1);
    chk("cross_lost", clk_lost, 0);
    chk("cross_ok", clk_ok, 0);
    lo_thr   = 16'd12;
    hi_thr   = 16'd20;
    mon_half = 20.0;
    wait_vld("back_a", lat);
    wait_vld("back_b", lat);
    chk_rng("back_cnt", meas_cnt, 15, 17);

    // 5: abort at window cycle 30, re-enable, then reset at window cycle 40
    repeat (30) @(negedge clk);
    en = 1'b0;
    vld_before = dut_vld_n;
    repeat (100) @(negedge clk);
    chk("abort_no_vld", dut_vld_n - vld_before, 0);
    chk_rng("abort_hold_cnt", meas_cnt, 15, 17);
    chk("abort_hold_ok", clk_ok, 1);
    chk("abort_state", dbg_state, 0);
    en = 1'b1;
    wait_vld("reen_vld", lat);
    chk("reen_lat", lat, FIRST_LAT);
    repeat (40) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
`endif

`ifdef CLKMON_STICKY_EN
    // 6: sticky lost flag, clear, and set winning over a coincident clear
    wait_vld("st_a", lat);
    wait_vld("st_b", lat);
    chk("st_lost_kept", clk_lost, 1);
    chk("st_ok_held0", clk_ok, 0);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("st_clr_lost", clk_lost, 0);
    chk("st_clr_slow", clk_slow, 0);
    chk("st_clr_ok", clk_ok, 1);
    mon_run = 1'b0;
    wait_vld("st_bad_a", lat);
    wait_vld("st_bad_b", lat);
    chk("st_bad_cnt", meas_cnt, 0);
    repeat (WINDOW - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("st_coinc_vld", meas_vld, 1);
    chk("st_coinc_lost", clk_lost, 1);
    mon_run = 1'b1;
`endif

    en = 1'b0;
    repeat (10) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
